// File: rtl/lii_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lii_pkg
// Shared definitions for the LII request arbiter and the AXI-to-LII memory
// wrappers that sit behind it.
//   arb_state_t       : request arbiter states (A_IDLE / A_LOCK)
//   LII_ID_W          : width of the LII src/dst route fields
//   LII_DW_DEF        : default LII flit data width
//   RESP_OKAY/SLVERR  : response codes shared with the wrappers
//   wrap_inc()        : modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package lii_pkg;

    typedef enum logic [0:0] {
        A_IDLE = 1'b0,
        A_LOCK = 1'b1
    } arb_state_t;

    localparam int LII_ID_W   = 8;
    localparam int LII_DW_DEF = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/lii_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// lii_req_arbiter_if
// One LII stream, optionally NP lanes wide (lane i occupies slice
// [i*DW +: DW] of tdata, [i*DW/8 +: DW/8] of tkeep/tstrb, [i*8 +: 8] of
// src/dst and bit i of tlast/tvalid/tready).
//   master : drives payload + tvalid, receives tready
//   slave  : receives payload + tvalid, drives tready
// -----------------------------------------------------------------------------
interface lii_req_arbiter_if #(
    parameter int NP = 1,
    parameter int DW = 1024
);
    logic [NP*DW-1:0]   tdata;
    logic [NP*DW/8-1:0] tkeep;
    logic [NP*DW/8-1:0] tstrb;
    logic [NP-1:0]      tlast;
    logic [NP-1:0]      tvalid;
    logic [NP-1:0]      tready;
    logic [NP*8-1:0]    src;
    logic [NP*8-1:0]    dst;

    modport master (
        output tdata, tkeep, tstrb, tlast, tvalid, src, dst,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tlast, tvalid, src, dst,
        output tready
    );
endinterface

// File: rtl/lii_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// N-way round-robin priority picker: returns the first set bit of i_valid
// searching upward from i_ptr and wrapping modulo N.
//   i_valid : request vector
//   i_ptr   : index with highest priority this cycle
//   o_idx   : selected index (0 when nothing is valid)
//   o_vld   : at least one request is valid
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]              i_valid,
    input  logic [$clog2(N)-1:0]      i_ptr,
    output logic [$clog2(N)-1:0]      o_idx,
    output logic                      o_vld
);
    localparam int PW = $clog2(N);

    // w_cand[k] is the port examined at search offset k from the pointer.
    logic [PW-1:0] w_cand [N];
    logic [N-1:0]  w_cand_vld;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign w_cand[gi]     = PW'((32'(i_ptr) + gi) % N);
            assign w_cand_vld[gi] = i_valid[w_cand[gi]];
        end
    endgenerate

    // Scan downward so the smallest offset is the last to assign.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand_vld[k]) begin
                o_idx = w_cand[k];
                o_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lii_req_arbiter.sv
// -----------------------------------------------------------------------------
// lii_req_arbiter
// Shares one LII request/response stream pair between N memory wrappers.
// Requests: round-robin arbitration with packet locking (a packet is never
// interleaved with another requester's flits). Responses: routed to the port
// whose cfg_port_id matches m_resp.dst; unmatched beats are accepted and
// dropped.
//   clk, rstn   : clock, synchronous active-low reset
//   s_req       : N-lane request input (slave)
//   m_req       : shared request output to the link (master)
//   m_resp      : shared response input from the link (slave)
//   s_resp      : N-lane response output (master); payload broadcast,
//                 only tvalid is per-lane
//   cfg_port_id : LII ID of each port (8 bits per port, unique)
//   drop_cnt    : saturating count of dropped response beats
//   drop_pulse  : one-cycle pulse, the cycle after each dropped beat
// -----------------------------------------------------------------------------
module lii_req_arbiter
    import lii_pkg::*;
#(
    parameter int N      = 4,
    parameter int LII_DW = LII_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    lii_req_arbiter_if.slave       s_req,
    lii_req_arbiter_if.master      m_req,
    lii_req_arbiter_if.slave       m_resp,
    lii_req_arbiter_if.master      s_resp,
    input  logic [N*LII_ID_W-1:0]  cfg_port_id,
    output logic [15:0]            drop_cnt,
    output logic                   drop_pulse
);
    localparam int PW = $clog2(N);
    localparam int KW = LII_DW / 8;

    arb_state_t    r_state;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_lock_id;
    logic [15:0]   r_drop_cnt;
    logic          r_drop_pulse;

    logic [PW-1:0] w_pick_idx;
    logic          w_pick_vld;
    logic [PW-1:0] w_gnt;
    logic          w_gnt_vld;
    logic          w_hs;

    // ---------------- request arbitration ----------------
    rr_pick #(.N(N)) u_rr_pick (
        .i_valid (s_req.tvalid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_vld   (w_pick_vld)
    );

    // While locked the owner keeps the grant even with tvalid low, so no
    // other port can slip in mid-packet.
    always_comb begin
        if (r_state == A_LOCK) begin
            w_gnt     = r_lock_id;
            w_gnt_vld = 1'b1;
        end else begin
            w_gnt     = w_pick_idx;
            w_gnt_vld = w_pick_vld;
        end
    end

    assign m_req.tdata  = s_req.tdata[32'(w_gnt) * LII_DW +: LII_DW];
    assign m_req.tkeep  = s_req.tkeep[32'(w_gnt) * KW +: KW];
    assign m_req.tstrb  = s_req.tstrb[32'(w_gnt) * KW +: KW];
    assign m_req.tlast  = s_req.tlast[w_gnt +: 1];
    assign m_req.src    = s_req.src[32'(w_gnt) * LII_ID_W +: LII_ID_W];
    assign m_req.dst    = s_req.dst[32'(w_gnt) * LII_ID_W +: LII_ID_W];
    assign m_req.tvalid = rstn & w_gnt_vld & s_req.tvalid[w_gnt];

    always_comb begin
        s_req.tready = '0;
        if (rstn && w_gnt_vld) begin
            s_req.tready[w_gnt] = m_req.tready[0];
        end
    end

    assign w_hs = m_req.tvalid[0] & m_req.tready[0];

    // ---------------- response routing ----------------
    logic [N-1:0]  w_id_hit;
    logic [N-1:0]  w_match;
    logic [PW-1:0] w_match_idx;
    logic          w_any;
    logic          w_drop;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_id_cmp
            assign w_id_hit[gi] = (cfg_port_id[gi*LII_ID_W +: LII_ID_W] == m_resp.dst);
        end
    endgenerate

    // Duplicate IDs resolve to the lowest index.
    always_comb begin
        w_match     = '0;
        w_match_idx = '0;
        w_any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_id_hit[k]) begin
                w_match_idx = PW'(k);
                w_any       = 1'b1;
            end
        end
        if (w_any) begin
            w_match[w_match_idx] = 1'b1;
        end
    end

    assign s_resp.tdata  = {N{m_resp.tdata}};
    assign s_resp.tkeep  = {N{m_resp.tkeep}};
    assign s_resp.tstrb  = {N{m_resp.tstrb}};
    assign s_resp.tlast  = {N{m_resp.tlast}};
    assign s_resp.src    = {N{m_resp.src}};
    assign s_resp.dst    = {N{m_resp.dst}};
    assign s_resp.tvalid = (rstn && m_resp.tvalid[0]) ? w_match : '0;

    // Unmatched beats are always accepted so a stray dst cannot wedge the link.
    assign m_resp.tready = !rstn ? 1'b0 : (w_any ? s_resp.tready[w_match_idx] : 1'b1);
    assign w_drop        = rstn & m_resp.tvalid[0] & ~w_any;

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= A_IDLE;
            r_rr_ptr     <= '0;
            r_lock_id    <= '0;
            r_drop_cnt   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            case (r_state)
                A_IDLE: begin
                    if (w_gnt_vld) begin
                        if (w_hs && m_req.tlast[0]) begin
                            r_rr_ptr <= PW'(wrap_inc(32'(w_gnt), N));
                        end else begin
                            // Also taken for valid-without-ready: the offered
                            // flit must stay granted until accepted.
                            r_state   <= A_LOCK;
                            r_lock_id <= w_gnt;
                        end
                    end
                end
                A_LOCK: begin
                    if (w_hs && m_req.tlast[0]) begin
                        r_state  <= A_IDLE;
                        r_rr_ptr <= PW'(wrap_inc(32'(r_lock_id), N));
                    end
                end
                default: r_state <= A_IDLE;
            endcase

            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign drop_cnt   = r_drop_cnt;
    assign drop_pulse = r_drop_pulse;
endmodule

// File: tb/tb_lii_req_arbiter.sv
module tb_lii_req_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int NCYC = 1500;
    localparam int TAIL = 60;

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic [N*8-1:0] cfg_port_id;
    logic [15:0]    drop_cnt;
    logic           drop_pulse;

    lii_req_arbiter_if #(.NP(N), .DW(DW)) s_req_if ();
    lii_req_arbiter_if #(.NP(1), .DW(DW)) m_req_if ();
    lii_req_arbiter_if #(.NP(1), .DW(DW)) m_resp_if ();
    lii_req_arbiter_if #(.NP(N), .DW(DW)) s_resp_if ();

    always #5 clk = ~clk;

    lii_req_arbiter #(.N(N), .LII_DW(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_req       (s_req_if),
        .m_req       (m_req_if),
        .m_resp      (m_resp_if),
        .s_resp      (s_resp_if),
        .cfg_port_id (cfg_port_id),
        .drop_cnt    (drop_cnt),
        .drop_pulse  (drop_pulse)
    );

    typedef struct {
        int            port;   // -1 marks a dropped response beat
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [KW-1:0] strb;
        logic          last;
        logic [7:0]    src;
        logic [7:0]    dst;
        int            cnt;    // expected drop_cnt after this drop
    } beat_t;

    beat_t req_q[$];
    beat_t resp_q[$];
    beat_t mon_e;

    int checks   = 0;
    int failures = 0;

    logic         exp_req_hs   = 1'b0;
    logic         exp_resp_rdy = 1'b0;
    logic [N-1:0] exp_resp_vld = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Flit content is a pure function of (port, packet seq, beat) so the
    // expected stream can be regenerated independently of the DUT.
    function automatic beat_t mk_req(input int p, input int s, input int b, input int len);
        beat_t t;
        t.port = p;
        t.data = {4'(p), 12'(s), 4'(b), 12'(s * 5 + b * 3 + p)};
        t.keep = KW'(s + b + p) | KW'(1);
        t.strb = ~t.keep;
        t.last = (b == len - 1);
        t.src  = 8'(8'h20 + p);
        t.dst  = 8'(s ^ (b << 4));
        t.cnt  = 0;
        return t;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [N-1:0] hv;
        if (!rstn) begin
            check("reset_forced_zero",
                  {s_req_if.tready, m_req_if.tvalid, s_resp_if.tvalid, m_resp_if.tready}, '0);
        end

        check("req_handshake", m_req_if.tvalid & m_req_if.tready, exp_req_hs);
        if (m_req_if.tvalid[0] && m_req_if.tready[0]) begin
            if (req_q.size() == 0) begin
                fail_now("req_unexpected");
            end else begin
                mon_e = req_q.pop_front();
                $display("req  port=%0d data=%h last=%0d", mon_e.port, m_req_if.tdata, m_req_if.tlast);
                check("req_flit",
                      {m_req_if.tdata, m_req_if.tkeep, m_req_if.tstrb, m_req_if.tlast, m_req_if.src, m_req_if.dst},
                      {mon_e.data, mon_e.keep, mon_e.strb, mon_e.last, mon_e.src, mon_e.dst});
                check("req_tready_onehot", s_req_if.tready, N'(1) << mon_e.port);
            end
        end

        check("resp_m_tready", m_resp_if.tready, exp_resp_rdy);
        check("resp_s_tvalid", s_resp_if.tvalid, exp_resp_vld);

        if (drop_pulse) begin
            if (resp_q.size() == 0 || resp_q[0].port >= 0) begin
                fail_now("drop_unexpected");
            end else begin
                mon_e = resp_q.pop_front();
                $display("drop data=%h cnt=%0d", mon_e.data, drop_cnt);
                check("drop_cnt", drop_cnt, mon_e.cnt);
            end
        end

        hv = s_resp_if.tvalid & s_resp_if.tready;
        if (hv != '0) begin
            if (resp_q.size() == 0 || resp_q[0].port < 0) begin
                fail_now("resp_unexpected");
            end else begin
                mon_e = resp_q.pop_front();
                $display("resp port=%0d data=%h last=%0d", mon_e.port, mon_e.data, mon_e.last);
                check("resp_port", hv, N'(1) << mon_e.port);
                check("resp_beat",
                      {s_resp_if.tdata[mon_e.port*DW +: DW], s_resp_if.tkeep[mon_e.port*KW +: KW],
                       s_resp_if.tlast[mon_e.port], s_resp_if.dst[mon_e.port*8 +: 8]},
                      {mon_e.data, mon_e.keep, mon_e.last, mon_e.dst});
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    initial begin
        bit            off[N];
        int            beat[N];
        int            len[N];
        int            seq[N];
        int            owner;
        int            nxt;
        int            g;
        int            mdl_drop;
        int            match;
        int            pick;
        bit            rst_now;
        bit            saturate;
        bit            quiet;
        bit            r_off;
        logic          rdy;
        logic [DW-1:0] r_data;
        logic [KW-1:0] r_keep;
        logic [7:0]    r_dst;
        logic          r_last;
        beat_t         cur;
        beat_t         rb;

        cfg_port_id = {8'h13, 8'h12, 8'h11, 8'h10};
        s_req_if.tdata  = '0;
        s_req_if.tkeep  = '0;
        s_req_if.tstrb  = '0;
        s_req_if.tlast  = '0;
        s_req_if.tvalid = '0;
        s_req_if.src    = '0;
        s_req_if.dst    = '0;
        m_req_if.tready = '0;
        m_resp_if.tdata  = '0;
        m_resp_if.tkeep  = '0;
        m_resp_if.tstrb  = '0;
        m_resp_if.tlast  = '0;
        m_resp_if.tvalid = '0;
        m_resp_if.src    = '0;
        m_resp_if.dst    = '0;
        s_resp_if.tready = '0;

        owner    = -1;
        nxt      = 0;
        mdl_drop = 0;
        r_off    = 1'b0;
        r_data   = '0;
        r_keep   = '0;
        r_dst    = 8'h00;
        r_last   = 1'b0;
        for (int p = 0; p < N; p++) begin
            off[p]  = 1'b0;
            beat[p] = 0;
            len[p]  = 1;
            seq[p]  = p * 100;
        end

        for (int cyc = 0; cyc < NCYC + TAIL; cyc++) begin
            @(posedge clk);
            #1;
            rst_now  = (cyc < 2) || (cyc == 400) || (cyc == 901);
            saturate = (cyc < 40);
            quiet    = (cyc >= NCYC);
            rstn     = !rst_now;

            if (cyc == 2) begin
                check("reset_drop_cnt", drop_cnt, 16'd0);
                check("reset_drop_pulse", drop_pulse, 1'b0);
            end

            // request sources: once offered, a flit stays until accepted
            for (int p = 0; p < N; p++) begin
                if (rst_now) begin
                    off[p]  = 1'b0;
                    beat[p] = 0;
                    seq[p]++;
                end else if (!off[p]) begin
                    if (quiet ? (beat[p] != 0) : (saturate || $urandom_range(0, 99) < 55)) begin
                        off[p] = 1'b1;
                        if (beat[p] == 0) begin
                            len[p] = (saturate || $urandom_range(0, 1) == 0) ? 1 : 4;
                        end
                    end
                end
                cur = mk_req(p, seq[p], beat[p], len[p]);
                s_req_if.tvalid[p]           = rst_now ? 1'($urandom_range(0, 1)) : off[p];
                s_req_if.tdata[p*DW +: DW]   = cur.data;
                s_req_if.tkeep[p*KW +: KW]   = cur.keep;
                s_req_if.tstrb[p*KW +: KW]   = cur.strb;
                s_req_if.tlast[p]            = cur.last;
                s_req_if.src[p*8 +: 8]       = cur.src;
                s_req_if.dst[p*8 +: 8]       = cur.dst;
            end
            m_req_if.tready = (saturate || quiet) ? 1'b1 : 1'($urandom_range(0, 99) < 70);

            // packet-level round robin: free arbiter takes the first offering
            // port at or after the priority port; a packet owner keeps the link
            exp_req_hs = 1'b0;
            if (rst_now) begin
                owner = -1;
                nxt   = 0;
            end else begin
                if (owner >= 0) begin
                    g = owner;
                end else begin
                    g = -1;
                    for (int k = N - 1; k >= 0; k--) begin
                        if (off[(nxt + k) % N]) g = (nxt + k) % N;
                    end
                end
                if (g >= 0) begin
                    if (off[g] && m_req_if.tready[0]) begin
                        cur = mk_req(g, seq[g], beat[g], len[g]);
                        req_q.push_back(cur);
                        exp_req_hs = 1'b1;
                        off[g]     = 1'b0;
                        if (cur.last) begin
                            owner   = -1;
                            nxt     = (g + 1) % N;
                            beat[g] = 0;
                            seq[g]++;
                        end else begin
                            owner = g;
                            beat[g]++;
                        end
                    end else begin
                        owner = g;
                    end
                end
            end

            // response source (link side, not reset)
            if (!r_off && !quiet && $urandom_range(0, 99) < 60) begin
                r_off  = 1'b1;
                r_data = $urandom;
                r_keep = KW'($urandom);
                pick   = $urandom_range(0, 5);
                r_dst  = (pick < 4) ? 8'(8'h10 + pick) : ((pick == 4) ? 8'h55 : 8'hA7);
                r_last = 1'($urandom_range(0, 1));
            end
            m_resp_if.tvalid = r_off;
            m_resp_if.tdata  = r_data;
            m_resp_if.tkeep  = r_keep;
            m_resp_if.tstrb  = ~r_keep;
            m_resp_if.tlast  = r_last;
            m_resp_if.src    = 8'h01;
            m_resp_if.dst    = r_dst;
            s_resp_if.tready = (quiet || saturate) ? '1 : N'($urandom);

            match = -1;
            for (int k = N - 1; k >= 0; k--) begin
                if (cfg_port_id[k*8 +: 8] == r_dst) match = k;
            end
            if (rst_now) begin
                rdy      = 1'b0;
                mdl_drop = 0;
            end else begin
                rdy = (match >= 0) ? s_resp_if.tready[match] : 1'b1;
            end
            exp_resp_rdy = rdy;
            exp_resp_vld = (!rst_now && r_off && match >= 0) ? (N'(1) << match) : '0;
            if (r_off && rdy) begin
                rb.port = match;
                rb.data = r_data;
                rb.keep = r_keep;
                rb.strb = ~r_keep;
                rb.last = r_last;
                rb.src  = 8'h01;
                rb.dst  = r_dst;
                rb.cnt  = 0;
                if (match < 0) begin
                    if (mdl_drop < 65535) mdl_drop++;
                    rb.cnt = mdl_drop;
                end
                resp_q.push_back(rb);
                r_off = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        check("req_queue_drained", req_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        check("drop_cnt_final", drop_cnt, 16'(mdl_drop));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lii_req_arbiter.md
# lii_req_arbiter

Shares one LII request/response stream pair between `N` AXI-to-LII memory wrappers in the lenet memory subsystem. It is the block that lets several top-level memory ports use a single LII link. Requests are arbitrated round-robin with packet-level locking, so a write header and its data beats are never interleaved with another requester's packet. Responses are routed back to the matching requester by comparing `lii_resp_dst` with each port's configured ID. Beats with no matching port are dropped and counted.

## Interface
- `N`, 4: number of requester ports (2..8).
- `LII_DW`, 1024: LII flit data width.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_req_tdata`  in  N*LII_DW  per-port request data; port i occupies slice [i*LII_DW +: LII_DW].
- `s_req_tkeep` / `s_req_tstrb`  in  N*LII_DW/8  per-port keep/strobe.
- `s_req_tlast` / `s_req_tvalid`  in  N  per-port last/valid.
- `s_req_src` / `s_req_dst`  in  N*8  per-port route fields.
- `s_req_tready`  out  N  per-port ready.
- `m_req_*`  out (`tready` in)  same widths as one port  shared request stream to the link.
- `m_resp_*`  in (`tready` out)  shared response stream: tdata, tkeep, tstrb, tlast, src, dst, tvalid, tready.
- `s_resp_*`  out (`tready` in)  N-wide flattened response streams, same slicing as requests.
- `cfg_port_id`  in  N*8  LII ID of port i; values must be unique.
- `drop_cnt`  out  16  saturating count of dropped unmatched response beats.
- `drop_pulse`  out  1  one-cycle pulse per dropped beat.

## Operation
- Request FSM states:
  - `A_IDLE`: no packet in progress.
  - `A_LOCK`: a packet from `lock_id` is in progress.
- Registers: `state`, `rr_ptr` (clog2(N) bits), `lock_id`.
- Grant in `A_IDLE`: the first port with `tvalid` searching upward from `rr_ptr`, wrapping modulo N. In `A_LOCK` the grant is `lock_id`.
- Request mux: `m_req_*` = granted port's fields. `s_req_tready[g]` = `m_req_tready`; every other port's tready is 0. With no grant, `m_req_tvalid` = 0.
- Transitions out of `A_IDLE` with a grant g:
  - handshake with tlast: stay in `A_IDLE`, `rr_ptr <= (g+1) mod N`.
  - any other case, including valid without handshake: `A_LOCK`, `lock_id <= g`. This guarantees an offered flit is never withdrawn.
- Transition out of `A_LOCK`: on handshake with tlast, go to `A_IDLE` and set `rr_ptr <= (lock_id+1) mod N`. Other ports wait, even if the locked port deasserts valid mid-packet.
- Response routing (per beat, combinational):
  - match = one-hot of `cfg_port_id[i] == m_resp_dst`.
  - Matched port i: `s_resp_tvalid[i]` = `m_resp_tvalid`, `m_resp_tready` = `s_resp_tready[i]`.
  - No match: `m_resp_tready` = 1 and the beat is dropped. `drop_pulse` is registered: it is asserted the cycle after the drop handshake. `drop_cnt` increments and saturates at 0xFFFF.
- Response payload fields are broadcast to all `s_resp` slices; only tvalid is gated.

## Timing
- Zero-cycle combinational request and response paths; no added latency.
- One packet per requester per arbitration round. A back-to-back single-flit stream from every port gets 1 flit/cycle, rotating 0,1,2,3,0…
- Reset (rstn low at a clock edge) sets `state=A_IDLE`, `rr_ptr=0`, `lock_id=0`, `drop_cnt=0`, `drop_pulse=0`.
- While rstn is low, all `s_req_tready`, `m_req_tvalid`, `s_resp_tvalid` and `m_resp_tready` are forced to 0.
- Reset mid-packet abandons the lock. Upstream wrappers are reset by the same rstn.
- Simultaneous tlast handshake and new valids: the next grant uses the updated `rr_ptr` on the following cycle.
- Duplicate `cfg_port_id` values: the lowest index wins. This case is unsupported but deterministic.

## Structure
- Package `lii_pkg`: `arb_state_t` enum {A_IDLE, A_LOCK}, the LII flit field widths, and the `RESP_OKAY`/`RESP_SLVERR` constants shared with the wrappers.
- One sub-module, `rr_pick`: parameterised N-way round-robin priority picker. Inputs are the valid vector and `rr_ptr`; outputs are the grant index and a grant-valid flag.
- Response routing stays inline.

## Test plan
- Ports 0–3 each offer one single-flit READ header every cycle, `m_req_tready`=1 → output sources 0,1,2,3,0,1 on consecutive cycles.
- Port 1 sends WRITE header plus 3 data beats (tlast on beat 4) while port 2 is valid throughout → four port-1 flits contiguous, then port 2.
- Port 0 valid while `m_req_tready`=0 for 5 cycles, port 3 becomes valid at cycle 2 → grant stays on port 0 until its handshake, and its tdata stays stable.
- `cfg_port_id`={0x10,0x11,0x12,0x13}, response beats with dst 0x12 (2 beats, tlast on the second) → delivered only on port 2. Backpressure from `s_resp_tready[2]`=0 stalls `m_resp_tready`.
- Response dst 0x55 for 3 beats → `m_resp_tready`=1, three `drop_pulse` pulses, `drop_cnt`=3. No `s_resp_tvalid` asserted.
- Assert rstn low for 1 cycle during a locked 4-beat packet → state returns to `A_IDLE` and `rr_ptr`=0. The next grant is the lowest-indexed valid port.
